// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding imem request at a time,
// EX redirects with stale-response dropping, and a registered valid/ready IF stream.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        if_ready,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] fetch_pc;
   logic [31:0] req_pc;
   logic        drop;
   logic        unused_pc_bits;

   assign unused_pc_bits = ^redirect_pc[1:0];

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: state_next = S_REQ;
         S_REQ:  if (imem_gnt) state_next = S_WAIT;
         S_WAIT: begin
            if (imem_rvalid) state_next = (drop || redirect_valid) ? S_REQ : S_HOLD;
         end
         S_HOLD: if (if_ready || redirect_valid) state_next = S_REQ;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      imem_req  = (state == S_REQ);
      imem_addr = {fetch_pc[31:2], 2'b00};
   end

   // A redirect always wins for fetch_pc; a grant in the same cycle still
   // issues the old address, whose response is then marked stale.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
         drop     <= 1'b0;
         if_valid <= 1'b0;
         if_instr <= NOP;
         if_pc    <= RESET_PC;
      end else begin
         if (redirect_valid)
            fetch_pc <= {redirect_pc[31:2], 2'b00};
         else if (state == S_REQ && imem_gnt)
            fetch_pc <= fetch_pc + 32'd4;

         case (state)
            S_REQ: begin
               if (imem_gnt) begin
                  req_pc <= fetch_pc;
                  drop   <= redirect_valid;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  drop <= 1'b0;
                  if (!drop && !redirect_valid) begin
                     if_instr <= imem_rdata;
                     if_pc    <= req_pc;
                     if_valid <= 1'b1;
                  end
               end else if (redirect_valid) begin
                  drop <= 1'b1;
               end
            end
            S_HOLD: begin
               if (if_ready || redirect_valid) if_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: a transaction-level model tracks the architectural
// fetch address, the single in-flight request and the delivered instruction.
module tb_fetch_ctrl;

   localparam logic [31:0] RPC   = 32'h0000_0000;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] DMASK = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_ready;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;

   fetch_ctrl #(.RESET_PC(RPC)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_ready(if_ready), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
   endtask

   // reference model state
   logic [31:0] m_fetch, m_addr, m_pc, m_instr;
   bit          m_out, m_stale, m_valid, m_idle;
   int          m_lat;
   int          delivered = 0;
   int          wrap_seen = 0;

   // stimulus knobs
   int          gnt_pct = 100, red_pct = 0, rdy_pct = 100, max_lat = 0;
   bit          frc_red = 0;
   logic [31:0] frc_tgt = '0;

   function automatic void model_reset();
      m_fetch = RPC; m_addr = RPC; m_pc = RPC; m_instr = NOP;
      m_out = 0; m_stale = 0; m_valid = 0; m_idle = 1; m_lat = 0;
   endfunction

   task automatic cycle(input bit rst);
      bit          g, rv, rd, rr, req;
      logic [31:0] tgt;
      @(negedge clk);
      req = !m_idle && !m_out && !m_valid;
      check("imem_req", {31'b0, imem_req}, {31'b0, req});
      check("imem_addr", imem_addr, m_fetch);
      check("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
      check("if_pc", if_pc, m_pc);
      check("if_instr", if_instr, m_instr);

      g   = ($urandom_range(99) < gnt_pct);
      rv  = m_out && (m_lat == 0);
      rd  = frc_red || ($urandom_range(99) < red_pct);
      tgt = frc_red ? frc_tgt : $urandom;
      frc_red = 0;
      rr  = ($urandom_range(99) < rdy_pct);

      reset          = rst;
      imem_gnt       = g;
      imem_rvalid    = rv;
      imem_rdata     = rv ? (m_addr ^ DMASK) : $urandom;
      redirect_valid = rd;
      redirect_pc    = tgt;
      if_ready       = rr;

      if (rst) begin
         model_reset();
      end else begin
         m_idle = 0;
         if (m_valid && (rr || rd)) m_valid = 0;
         if (rv) begin
            m_out = 0;
            if (!m_stale && !rd) begin
               m_valid = 1; m_pc = m_addr; m_instr = m_addr ^ DMASK;
               delivered++;
               if (m_addr == 32'h0 && m_pc == 32'h0 && wrap_seen == 1) wrap_seen = 2;
               if (m_addr == 32'hFFFF_FFFC) wrap_seen = 1;
            end
         end else if (m_out) begin
            if (rd) m_stale = 1;
            m_lat--;
         end
         if (req && g) begin
            m_out = 1; m_addr = m_fetch; m_stale = rd;
            m_lat = $urandom_range(max_lat);
         end
         if (rd)            m_fetch = {tgt[31:2], 2'b00};
         else if (req && g) m_fetch = m_fetch + 32'd4;
      end
   endtask

   initial begin
      reset = 1'b1; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
      redirect_valid = 0; redirect_pc = '0; if_ready = 0;
      model_reset();

      // reset, then zero-wait memory streaming 0x0, 0x4, 0x8 ...
      cycle(1); cycle(1);
      for (int i = 0; i < 12; i++) cycle(0);

      // grant withheld in REQ, then released
      gnt_pct = 0;
      for (int i = 0; i < 6; i++) cycle(0);
      gnt_pct = 100;
      for (int i = 0; i < 4; i++) cycle(0);

      // consumer stall in HOLD
      rdy_pct = 0;
      for (int i = 0; i < 6; i++) cycle(0);
      rdy_pct = 100;
      for (int i = 0; i < 6; i++) cycle(0);

      // redirect while waiting on a slow response
      max_lat = 3;
      cycle(0); cycle(0);
      frc_red = 1; frc_tgt = 32'h0000_0103;
      for (int i = 0; i < 14; i++) cycle(0);

      // redirect to the top of memory; the following fetch wraps to 0
      max_lat = 0;
      frc_red = 1; frc_tgt = 32'hFFFF_FFFF;
      for (int i = 0; i < 10; i++) cycle(0);
      check("wrap_delivered", wrap_seen, 2);

      // reset with a request in flight
      max_lat = 2;
      for (int i = 0; i < 3; i++) cycle(0);
      cycle(1);
      for (int i = 0; i < 6; i++) cycle(0);

      // randomized traffic
      gnt_pct = 60; red_pct = 10; rdy_pct = 60; max_lat = 3;
      for (int i = 0; i < 4000; i++) cycle($urandom_range(999) < 4);

      check("delivery_progress", {31'b0, delivered > 200}, 32'd1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
